// File: rtl/z16_pkg.sv
// Shared constants and ALU operation codes for the Z16 core.
package z16_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_AW     = 4;
  localparam int ALU_CTRL_W = 4;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_MUL = 4'd2,
    ALU_DIV = 4'd3,
    ALU_OR  = 4'd4,
    ALU_AND = 4'd5,
    ALU_XOR = 4'd6,
    ALU_SHL = 4'd7,
    ALU_SHR = 4'd8
  } alu_ctrl_e;

endpackage

// File: rtl/z16_operand_fetch_if.sv
// Issue, ALU and debug signals between the decoder/ALU side (master) and the operand-fetch stage (slave).
interface z16_operand_fetch_if #(
  parameter int DATA_W = z16_pkg::DATA_W,
  parameter int REG_AW = z16_pkg::REG_AW
);

  logic                          i_valid;
  logic                          o_ready;
  logic                          i_hold;
  logic [z16_pkg::ALU_CTRL_W-1:0] i_ctrl;
  logic [REG_AW-1:0]             i_rd;
  logic [REG_AW-1:0]             i_rs1;
  logic [REG_AW-1:0]             i_rs2;
  logic [DATA_W-1:0]             i_imm;
  logic                          i_use_imm;
  logic [DATA_W-1:0]             o_alu_a;
  logic [DATA_W-1:0]             o_alu_b;
  logic [z16_pkg::ALU_CTRL_W-1:0] o_alu_ctrl;
  logic                          o_alu_valid;
  logic [DATA_W-1:0]             i_alu_result;
  logic [REG_AW-1:0]             i_dbg_addr;
  logic [DATA_W-1:0]             o_dbg_data;
  logic [15:0]                   o_retired;

  modport master (
    output i_valid, i_hold, i_ctrl, i_rd, i_rs1, i_rs2, i_imm, i_use_imm,
    output i_alu_result, i_dbg_addr,
    input  o_ready, o_alu_a, o_alu_b, o_alu_ctrl, o_alu_valid, o_dbg_data, o_retired
  );

  modport slave (
    input  i_valid, i_hold, i_ctrl, i_rd, i_rs1, i_rs2, i_imm, i_use_imm,
    input  i_alu_result, i_dbg_addr,
    output o_ready, o_alu_a, o_alu_b, o_alu_ctrl, o_alu_valid, o_dbg_data, o_retired
  );

endinterface

// File: rtl/z16_regfile.sv
// General register file: two combinational read ports, a debug read port and one write port.
module z16_regfile #(
  parameter int DATA_W = z16_pkg::DATA_W,
  parameter int REG_N  = 16,
  parameter int REG_AW = $clog2(REG_N)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [REG_AW-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [REG_AW-1:0] i_rd0_addr,
  output logic [DATA_W-1:0] o_rd0_data,
  input  logic [REG_AW-1:0] i_rd1_addr,
  output logic [DATA_W-1:0] o_rd1_data,
  input  logic [REG_AW-1:0] i_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_data
);

  // Flops rather than block RAM: every register must clear on reset.
  logic [DATA_W-1:0] regs_reg [REG_N];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < REG_N; i++) regs_reg[i] <= '0;
    end else if (i_wr_en) begin
      regs_reg[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd0_data = regs_reg[i_rd0_addr];
  assign o_rd1_data = regs_reg[i_rd1_addr];
  assign o_dbg_data = regs_reg[i_dbg_addr];

endmodule

// File: rtl/z16_operand_fetch.sv
// Z16 operand-fetch / write-back stage: reads sources, registers them toward the ALU
// and writes the ALU result back one cycle later, with a result bypass for dependencies.
module z16_operand_fetch #(
  parameter int DATA_W = z16_pkg::DATA_W,
  parameter int REG_N  = 16
) (
  input logic                i_clk,
  input logic                i_rst_n,
  z16_operand_fetch_if.slave bus
);

  localparam int REG_AW = $clog2(REG_N);
  localparam int CW     = z16_pkg::ALU_CTRL_W;

  logic              accept;
  logic              wb_en;
  logic              byp_rs1;
  logic              byp_rs2;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic [DATA_W-1:0] opnd_a_next;
  logic [DATA_W-1:0] opnd_b_next;

  logic [DATA_W-1:0] ex_a_reg;
  logic [DATA_W-1:0] ex_b_reg;
  logic [CW-1:0]     ex_ctrl_reg;
  logic [REG_AW-1:0] ex_rd_reg;
  logic              ex_valid_reg;
  logic [15:0]       retired_reg;

  assign bus.o_ready = !bus.i_hold;
  assign accept      = bus.i_valid && !bus.i_hold;
  assign wb_en       = ex_valid_reg && !bus.i_hold;

  // The result being written this edge is not yet in the array; forward it instead.
  assign byp_rs1 = wb_en && (ex_rd_reg == bus.i_rs1);
  assign byp_rs2 = wb_en && (ex_rd_reg == bus.i_rs2);

  z16_regfile #(
    .DATA_W (DATA_W),
    .REG_N  (REG_N),
    .REG_AW (REG_AW)
  ) u_regfile (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_wr_en    (wb_en),
    .i_wr_addr  (ex_rd_reg),
    .i_wr_data  (bus.i_alu_result),
    .i_rd0_addr (bus.i_rs1),
    .o_rd0_data (rs1_data),
    .i_rd1_addr (bus.i_rs2),
    .o_rd1_data (rs2_data),
    .i_dbg_addr (bus.i_dbg_addr),
    .o_dbg_data (bus.o_dbg_data)
  );

  always_comb begin
    opnd_b_next = byp_rs1 ? bus.i_alu_result : rs1_data;
    opnd_a_next = rs2_data;
    if (bus.i_use_imm) begin
      opnd_a_next = bus.i_imm;
    end else if (byp_rs2) begin
      opnd_a_next = bus.i_alu_result;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_a_reg     <= '0;
      ex_b_reg     <= '0;
      ex_ctrl_reg  <= '0;
      ex_rd_reg    <= '0;
      ex_valid_reg <= 1'b0;
    end else if (!bus.i_hold) begin
      ex_valid_reg <= accept;
      if (accept) begin
        ex_a_reg    <= opnd_a_next;
        ex_b_reg    <= opnd_b_next;
        ex_ctrl_reg <= bus.i_ctrl;
        ex_rd_reg   <= bus.i_rd;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      retired_reg <= '0;
    end else if (wb_en) begin
      retired_reg <= retired_reg + 16'd1;
    end
  end

  assign bus.o_alu_a     = ex_a_reg;
  assign bus.o_alu_b     = ex_b_reg;
  assign bus.o_alu_ctrl  = ex_ctrl_reg;
  assign bus.o_alu_valid = ex_valid_reg;
  assign bus.o_retired   = retired_reg;

endmodule

// File: tb/tb_z16_operand_fetch.sv
// Directed bench for z16_operand_fetch: architectural-order model plus per-cycle comparison.
module tb_z16_operand_fetch;
  import z16_pkg::*;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  z16_operand_fetch_if bus ();

  z16_operand_fetch #(.DATA_W(16), .REG_N(16)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  bit quiet = 1'b0;
  logic [3:0] dbg_rot = 4'd0;

  function automatic logic [15:0] alu_f(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
    case (c)
      ALU_ADD: return a + b;
      ALU_SUB: return b - a;
      ALU_MUL: return 16'(a * b);
      ALU_DIV: return (a == 16'd0) ? 16'hFFFF : b / a;
      ALU_OR:  return a | b;
      ALU_AND: return a & b;
      ALU_XOR: return a ^ b;
      ALU_SHL: return b << a[3:0];
      ALU_SHR: return b >> a[3:0];
      default: return 16'd0;
    endcase
  endfunction

  assign bus.i_alu_result = alu_f(bus.o_alu_ctrl, bus.o_alu_a, bus.o_alu_b);

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: arch_r is the in-order architectural state (every accepted instruction
  // completes immediately); vis_r is what has actually been written back.
  logic [15:0] arch_r [16];
  logic [15:0] vis_r  [16];
  logic        pend_v;
  logic [15:0] pend_a, pend_b, pend_res;
  logic [3:0]  pend_ctrl, pend_rd;
  logic [15:0] m_retired;

  initial begin
    for (int i = 0; i < 16; i++) begin arch_r[i] = 16'd0; vis_r[i] = 16'd0; end
    pend_v = 1'b0; pend_a = 16'd0; pend_b = 16'd0; pend_res = 16'd0;
    pend_ctrl = 4'd0; pend_rd = 4'd0; m_retired = 16'd0;
    forever begin
      @(posedge i_clk or negedge i_rst_n);
      if (!i_rst_n) begin
        for (int i = 0; i < 16; i++) begin arch_r[i] = 16'd0; vis_r[i] = 16'd0; end
        pend_v = 1'b0;
        m_retired = 16'd0;
      end else if (!bus.i_hold) begin
        if (pend_v) begin
          vis_r[pend_rd] = pend_res;
          m_retired = m_retired + 16'd1;
        end
        pend_v = bus.i_valid;
        if (bus.i_valid) begin
          pend_a    = bus.i_use_imm ? bus.i_imm : arch_r[bus.i_rs2];
          pend_b    = arch_r[bus.i_rs1];
          pend_ctrl = bus.i_ctrl;
          pend_rd   = bus.i_rd;
          pend_res  = alu_f(pend_ctrl, pend_a, pend_b);
          arch_r[pend_rd] = pend_res;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge i_clk);
      chk("ready", 16'(bus.o_ready), 16'(!bus.i_hold));
      chk("alu_valid", 16'(bus.o_alu_valid), 16'(pend_v));
      if (pend_v) begin
        chk("alu_a", bus.o_alu_a, pend_a);
        chk("alu_b", bus.o_alu_b, pend_b);
        chk("alu_ctrl", 16'(bus.o_alu_ctrl), 16'(pend_ctrl));
      end
      chk("retired", bus.o_retired, m_retired);
      chk("dbg", bus.o_dbg_data, vis_r[bus.i_dbg_addr]);
    end
  end

  task automatic step(input logic v, input logic h, input logic [3:0] c, input logic [3:0] rd,
                      input logic [3:0] rs1, input logic [3:0] rs2, input logic [15:0] imm,
                      input logic ui);
    bus.i_valid = v; bus.i_hold = h; bus.i_ctrl = c; bus.i_rd = rd;
    bus.i_rs1 = rs1; bus.i_rs2 = rs2; bus.i_imm = imm; bus.i_use_imm = ui;
    bus.i_dbg_addr = dbg_rot;
    dbg_rot = dbg_rot + 4'd1;
    if (!quiet)
      $display("tx t=%0t valid=%0b hold=%0b ctrl=%0d rd=%0d rs1=%0d rs2=%0d imm=%h use_imm=%0b",
               $time, v, h, c, rd, rs1, rs2, imm, ui);
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 16'd0, 1'b0);
  endtask

  task automatic peek(input logic [3:0] ad, input logic [15:0] exp, input string nm);
    bus.i_dbg_addr = ad;
    #1;
    chk(nm, bus.o_dbg_data, exp);
  endtask

  initial begin
    bus.i_valid = 1'b0; bus.i_hold = 1'b0; bus.i_ctrl = 4'd0; bus.i_rd = 4'd0;
    bus.i_rs1 = 4'd0; bus.i_rs2 = 4'd0; bus.i_imm = 16'd0; bus.i_use_imm = 1'b0;
    bus.i_dbg_addr = 4'd0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;

    // Reset state
    for (int a = 0; a < 16; a++) peek(4'(a), 16'h0000, "rst_dbg");
    chk("rst_alu_valid", 16'(bus.o_alu_valid), 16'd0);
    chk("rst_retired", bus.o_retired, 16'd0);

    // Immediate load
    step(1'b1, 1'b0, ALU_ADD, 4'd1, 4'd0, 4'd0, 16'h0005, 1'b1);
    chk("imm_a", bus.o_alu_a, 16'h0005);
    chk("imm_b", bus.o_alu_b, 16'h0000);
    idle();
    peek(4'd1, 16'h0005, "imm_r1");
    chk("imm_retired", bus.o_retired, 16'd1);

    // Back-to-back dependency through the bypass
    step(1'b1, 1'b0, ALU_SUB, 4'd2, 4'd1, 4'd0, 16'h0003, 1'b1);
    chk("sub_a", bus.o_alu_a, 16'h0003);
    chk("sub_b", bus.o_alu_b, 16'h0005);
    step(1'b1, 1'b0, ALU_ADD, 4'd3, 4'd2, 4'd2, 16'h0000, 1'b0);
    chk("byp_a", bus.o_alu_a, 16'h0002);
    chk("byp_b", bus.o_alu_b, 16'h0002);
    idle();
    peek(4'd2, 16'h0002, "dep_r2");
    peek(4'd3, 16'h0004, "dep_r3");
    chk("dep_retired", bus.o_retired, 16'd3);

    // Hold with an instruction in EX
    step(1'b1, 1'b0, ALU_XOR, 4'd4, 4'd3, 4'd0, 16'h00F0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, ALU_ADD, 4'd5, 4'd4, 4'd4, 16'h0000, 1'b0);
      chk("hold_ready", 16'(bus.o_ready), 16'd0);
      chk("hold_a", bus.o_alu_a, 16'h00F0);
      chk("hold_b", bus.o_alu_b, 16'h0004);
      chk("hold_retired", bus.o_retired, 16'd3);
      peek(4'd4, 16'h0000, "hold_r4");
    end
    idle();
    peek(4'd4, 16'h00F4, "hold_wb_r4");
    peek(4'd5, 16'h0000, "hold_no_r5");
    idle();
    chk("hold_once", bus.o_retired, 16'd4);

    // Reset while EX holds a live instruction
    step(1'b1, 1'b0, ALU_ADD, 4'd7, 4'd1, 4'd0, 16'h1234, 1'b1);
    chk("mid_valid", 16'(bus.o_alu_valid), 16'd1);
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 16'(bus.o_alu_valid), 16'd0);
    idle();
    idle();
    i_rst_n = 1'b1;
    peek(4'd7, 16'h0000, "mid_r7");
    peek(4'd1, 16'h0000, "mid_r1");
    chk("mid_retired", bus.o_retired, 16'd0);

    // Chain with shift and or: bypass on rs1 while rs2 comes from the array
    step(1'b1, 1'b0, ALU_ADD, 4'd8, 4'd0, 4'd0, 16'h0003, 1'b1);
    step(1'b1, 1'b0, ALU_SHL, 4'd9, 4'd8, 4'd0, 16'h0004, 1'b1);
    chk("shl_b", bus.o_alu_b, 16'h0003);
    step(1'b1, 1'b0, ALU_OR, 4'd8, 4'd9, 4'd8, 16'h0000, 1'b0);
    chk("or_a", bus.o_alu_a, 16'h0003);
    chk("or_b", bus.o_alu_b, 16'h0030);
    idle();
    peek(4'd8, 16'h0033, "or_r8");
    chk("chain_retired", bus.o_retired, 16'd3);

    // Retire counter wrap
    quiet = 1'b1;
    for (int n = 0; n < 65532; n++)
      step(1'b1, 1'b0, ALU_ADD, 4'd10, 4'd10, 4'd0, 16'h0001, 1'b1);
    idle();
    quiet = 1'b0;
    chk("wrap_ffff", bus.o_retired, 16'hFFFF);
    step(1'b1, 1'b0, ALU_ADD, 4'd10, 4'd10, 4'd0, 16'h0001, 1'b1);
    idle();
    chk("wrap_zero", bus.o_retired, 16'h0000);
    peek(4'd10, 16'hFFFD, "wrap_r10");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
